gshare_bp: RTL and testbench

GSHARE_BP -- requirements
Module: gshare_bp

---
 rtl/rv32i_types.sv | 14 +
 rtl/gshare_bp_if.sv | 38 +++
 rtl/bp_table.sv | 39 +++
 rtl/gshare_bp.sv | 92 +++++++++
 tb/tb_gshare_bp.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared branch-predictor types and defaults.
// The prediction record is sized for the default index width.
package rv32i_types;
  localparam int         BP_IDX_BITS = 8;
  localparam logic [1:0] BP_PHT_INIT = 2'b01;

  typedef struct packed {
    logic [31:0]            pc;
    logic                   taken;
    logic [31:0]            target;
    logic [BP_IDX_BITS-1:0] gshare;
    logic [1:0]             pht_value;
  } bp_pred_t;
endpackage

// File: rtl/gshare_bp_if.sv
// Fetch lookup, resolve-time table updates and registered prediction outputs.
interface gshare_bp_if
  import rv32i_types::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS
) ();
  logic                fetch_valid;
  logic [31:0]         fetch_pc;
  logic                fetch_stall;
  logic                flush;
  logic                pht_web;
  logic [IDX_BITS-1:0] pht_addr;
  logic [1:0]          pht_in;
  logic                branch_taken;
  logic                btb_web;
  logic [IDX_BITS-1:0] btb_addr;
  logic [31:0]         btb_din;
  logic                pred_valid;
  logic [31:0]         pred_pc;
  logic                pred_taken;
  logic [31:0]         pred_target;
  logic [IDX_BITS-1:0] pred_gshare;
  logic [1:0]          pred_pht_value;

  modport master (
    output fetch_valid, fetch_pc, fetch_stall, flush,
    output pht_web, pht_addr, pht_in, branch_taken,
    output btb_web, btb_addr, btb_din,
    input  pred_valid, pred_pc, pred_taken, pred_target, pred_gshare, pred_pht_value
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_stall, flush,
    input  pht_web, pht_addr, pht_in, branch_taken,
    input  btb_web, btb_addr, btb_din,
    output pred_valid, pred_pc, pred_taken, pred_target, pred_gshare, pred_pht_value
  );
endinterface

// File: rtl/bp_table.sv
// 1R1W table with write-first read; only bits set in RST_MASK are reset.
module bp_table
  import rv32i_types::*;
#(
  parameter int               IDX_BITS = BP_IDX_BITS,
  parameter int               WIDTH    = 2,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter logic [WIDTH-1:0] RST_MASK = '1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] raddr,
  output logic [WIDTH-1:0]    rdata,
  input  logic                web,
  input  logic [IDX_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata
);
  localparam int DEPTH = 1 << IDX_BITS;

  logic [WIDTH-1:0] mem_rst [DEPTH];
  logic [WIDTH-1:0] mem_nr  [DEPTH];
  logic [WIDTH-1:0] stored;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_rst[i] <= RST_VAL;
    end else if (!web) begin
      mem_rst[waddr] <= wdata;
    end
  end

  // Bits outside the mask (e.g. BTB targets) need no reset: they are qualified elsewhere.
  always_ff @(posedge clk) begin
    if (!web) mem_nr[waddr] <= wdata;
  end

  assign stored = (mem_rst[raddr] & RST_MASK) | (mem_nr[raddr] & ~RST_MASK);
  assign rdata  = (!web && (waddr == raddr)) ? wdata : stored;
endmodule

// File: rtl/gshare_bp.sv
// Gshare direction predictor with BTB; GHR advances only on resolved branches.
module gshare_bp
  import rv32i_types::*;
#(
  parameter int         IDX_BITS = BP_IDX_BITS,
  parameter logic [1:0] PHT_INIT = BP_PHT_INIT
) (
  input logic        clk,
  input logic        rst,
  gshare_bp_if.slave bp
);
  logic [IDX_BITS-1:0] ghr;
  logic [IDX_BITS-1:0] pc_idx;
  logic [IDX_BITS-1:0] idx;
  logic [1:0]          pht_rd;
  logic [32:0]         btb_rd;
  logic                taken;
  logic                pred_valid_q;
  bp_pred_t            pred_d;
  bp_pred_t            pred_q;

  assign pc_idx = bp.fetch_pc[IDX_BITS+1:2];
  assign idx    = pc_idx ^ ghr;

  bp_table #(
    .IDX_BITS (IDX_BITS),
    .WIDTH    (2),
    .RST_VAL  (PHT_INIT),
    .RST_MASK (2'b11)
  ) u_pht (
    .clk   (clk),
    .rst   (rst),
    .raddr (idx),
    .rdata (pht_rd),
    .web   (bp.pht_web),
    .waddr (bp.pht_addr),
    .wdata (bp.pht_in)
  );

  // Bit 32 is the valid flag; the target bits stay unreset.
  bp_table #(
    .IDX_BITS (IDX_BITS),
    .WIDTH    (33),
    .RST_VAL  (33'h0),
    .RST_MASK ({1'b1, 32'h0})
  ) u_btb (
    .clk   (clk),
    .rst   (rst),
    .raddr (pc_idx),
    .rdata (btb_rd),
    .web   (bp.btb_web),
    .waddr (bp.btb_addr),
    .wdata ({1'b1, bp.btb_din})
  );

  always_comb begin
    taken            = pht_rd[1] & btb_rd[32];
    pred_d           = '0;
    pred_d.pc        = bp.fetch_pc;
    pred_d.taken     = taken;
    pred_d.target    = taken ? btb_rd[31:0] : bp.fetch_pc + 32'd4;
    pred_d.gshare    = BP_IDX_BITS'(idx);
    pred_d.pht_value = pht_rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (!bp.pht_web) begin
      ghr <= {ghr[IDX_BITS-2:0], bp.branch_taken};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_q <= 1'b0;
      pred_q       <= '0;
    end else if (bp.flush) begin
      pred_valid_q <= 1'b0;
    end else if (!bp.fetch_stall) begin
      pred_valid_q <= bp.fetch_valid;
      if (bp.fetch_valid) pred_q <= pred_d;
    end
  end

  assign bp.pred_valid     = pred_valid_q;
  assign bp.pred_pc        = pred_q.pc;
  assign bp.pred_taken     = pred_q.taken;
  assign bp.pred_target    = pred_q.target;
  assign bp.pred_gshare    = IDX_BITS'(pred_q.gshare);
  assign bp.pred_pht_value = pred_q.pht_value;
endmodule

// File: tb/tb_gshare_bp.sv
// Bench for gshare_bp: array-based reference model plus directed literal checks.
module tb_gshare_bp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gshare_bp_if #(.IDX_BITS(8)) bp ();

  gshare_bp #(.IDX_BITS(8), .PHT_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  // Reference state
  logic [1:0]  m_pht  [256];
  bit          m_btbv [256];
  logic [31:0] m_btbt [256];
  logic [7:0]  m_ghr;
  bit          m_valid;
  logic [31:0] m_pc, m_target;
  bit          m_taken;
  logic [7:0]  m_gshare;
  logic [1:0]  m_pht_value;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) begin
        m_pht[i]  = 2'b01;
        m_btbv[i] = 1'b0;
      end
      m_ghr = 0; m_valid = 0; m_pc = 0; m_target = 0;
      m_taken = 0; m_gshare = 0; m_pht_value = 0;
    end else begin
      int unsigned b, i;
      b = (bp.fetch_pc >> 2) % 256;
      i = b ^ int'(m_ghr);
      // Writes land before the lookup reads the tables (write-first).
      if (!bp.pht_web) m_pht[bp.pht_addr] = bp.pht_in;
      if (!bp.btb_web) begin
        m_btbv[bp.btb_addr] = 1'b1;
        m_btbt[bp.btb_addr] = bp.btb_din;
      end
      if (bp.flush) m_valid = 0;
      else if (!bp.fetch_stall) begin
        m_valid = bp.fetch_valid;
        if (bp.fetch_valid) begin
          m_pc        = bp.fetch_pc;
          m_pht_value = m_pht[i];
          m_taken     = (m_pht[i] >= 2) && m_btbv[b];
          m_target    = m_taken ? m_btbt[b] : bp.fetch_pc + 4;
          m_gshare    = 8'(i);
        end
      end
      if (!bp.pht_web) m_ghr = 8'((int'(m_ghr) * 2 + int'(bp.branch_taken)) % 256);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("model_valid", 32'(bp.pred_valid), 32'(m_valid));
      if (m_valid) begin
        chk("model_pc", bp.pred_pc, m_pc);
        chk("model_taken", 32'(bp.pred_taken), 32'(m_taken));
        chk("model_target", bp.pred_target, m_target);
        chk("model_gshare", 32'(bp.pred_gshare), 32'(m_gshare));
        chk("model_pht", 32'(bp.pred_pht_value), 32'(m_pht_value));
      end
    end
  end

  task automatic idle();
    bp.fetch_valid = 0; bp.fetch_pc = 0; bp.fetch_stall = 0; bp.flush = 0;
    bp.pht_web = 1; bp.pht_addr = 0; bp.pht_in = 0; bp.branch_taken = 0;
    bp.btb_web = 1; bp.btb_addr = 0; bp.btb_din = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic lookup(input logic [31:0] pc);
    bp.fetch_valid = 1; bp.fetch_pc = pc;
  endtask

  task automatic pht_wr(input logic [7:0] a, input logic [1:0] v, input logic t);
    bp.pht_web = 0; bp.pht_addr = a; bp.pht_in = v; bp.branch_taken = t;
  endtask

  task automatic btb_wr(input logic [7:0] a, input logic [31:0] d);
    bp.btb_web = 0; bp.btb_addr = a; bp.btb_din = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bp.pred_valid), 0);
    chk("rst_pc", bp.pred_pc, 0);
    chk("rst_taken", 32'(bp.pred_taken), 0);
    chk("rst_target", bp.pred_target, 0);
    chk("rst_gshare", 32'(bp.pred_gshare), 0);
    chk("rst_pht", 32'(bp.pred_pht_value), 0);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1;

    lookup(32'h1000); tick();
    chk("t1_valid", 32'(bp.pred_valid), 1);
    chk("t1_taken", 32'(bp.pred_taken), 0);
    chk("t1_target", bp.pred_target, 32'h1004);
    chk("t1_gshare", 32'(bp.pred_gshare), 32'h00);
    chk("t1_pht", 32'(bp.pred_pht_value), 32'h1);

    btb_wr(8'h04, 32'h2000); tick();
    pht_wr(8'h04, 2'b11, 1'b0); tick();
    lookup(32'h1010); tick();
    chk("t2_taken", 32'(bp.pred_taken), 1);
    chk("t2_target", bp.pred_target, 32'h2000);
    chk("t2_gshare", 32'(bp.pred_gshare), 32'h04);
    chk("t2_pht", 32'(bp.pred_pht_value), 32'h3);

    pht_wr(8'h10, 2'b01, 1'b1); tick();
    pht_wr(8'h10, 2'b01, 1'b0); tick();
    pht_wr(8'h10, 2'b01, 1'b1); tick();
    lookup(32'h1000); tick();
    chk("t3_gshare", 32'(bp.pred_gshare), 32'h05);

    lookup(32'h1040); tick();
    for (int k = 0; k < 3; k++) begin
      bp.fetch_stall = 1; lookup(32'h2000); pht_wr(8'h30, 2'b10, 1'b0); tick();
      chk("stall_pc", bp.pred_pc, 32'h1040);
      chk("stall_valid", 32'(bp.pred_valid), 1);
    end
    bp.fetch_stall = 1; bp.flush = 1; lookup(32'h2000); tick();
    chk("flush_valid", 32'(bp.pred_valid), 0);

    lookup(32'h1010); tick();
    @(posedge clk);
    #3 rst = 0;
    #1;
    chk("arst_valid", 32'(bp.pred_valid), 0);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1;
    lookup(32'h1010); tick();
    chk("post_rst_valid", 32'(bp.pred_valid), 1);
    chk("post_rst_taken", 32'(bp.pred_taken), 0);
    chk("post_rst_pht", 32'(bp.pred_pht_value), 32'h1);
    chk("post_rst_gshare", 32'(bp.pred_gshare), 32'h04);

    btb_wr(8'h08, 32'h3000); tick();
    pht_wr(8'h08, 2'b11, 1'b1); lookup(32'h1020); tick();
    chk("fwd_pht", 32'(bp.pred_pht_value), 32'h3);
    chk("fwd_taken", 32'(bp.pred_taken), 1);
    chk("fwd_target", bp.pred_target, 32'h3000);

    pht_wr(8'h23, 2'b10, 1'b0); btb_wr(8'h21, 32'h4000); tick();
    lookup(32'h0000_0084); tick();
    chk("dual_gshare", 32'(bp.pred_gshare), 32'h23);
    chk("dual_pht", 32'(bp.pred_pht_value), 32'h2);
    chk("dual_target", bp.pred_target, 32'h4000);

    for (int n = 0; n < 300; n++) begin
      bp.fetch_valid  = ($urandom_range(0, 3) != 0);
      bp.fetch_pc     = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      bp.fetch_stall  = ($urandom_range(0, 7) == 0);
      bp.flush        = ($urandom_range(0, 9) == 0);
      bp.pht_web      = ($urandom_range(0, 2) != 0);
      bp.pht_addr     = 8'($urandom_range(0, 255));
      bp.pht_in       = 2'($urandom_range(0, 3));
      bp.branch_taken = 1'($urandom_range(0, 1));
      bp.btb_web      = ($urandom_range(0, 2) != 0);
      bp.btb_addr     = 8'($urandom_range(0, 255));
      bp.btb_din      = $urandom;
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
